// File: rtl/cell_exerciser_pkg.sv
// Shared definitions for the Wishbone standard-cell exerciser: register map,
// FSM encoding, MISR polynomial and CTRL/STATUS bit positions.
package cell_exerciser_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DRIVE  = 8'h08;
    localparam logic [7:0] OFF_SAMPLE = 8'h0C;
    localparam logic [7:0] OFF_COUNT  = 8'h10;
    localparam logic [7:0] OFF_SIG    = 8'h14;
    localparam logic [7:0] OFF_PIDX   = 8'h18;

    localparam logic [31:0] MISR_POLY = 32'h0040_0007;

    localparam int CTRL_START     = 0;
    localparam int CTRL_MODE      = 1;
    localparam int CTRL_CLR       = 2;
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_STATE_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Merge a 32-bit write into an existing value, one byte lane per select bit.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cell_exerciser_misr.sv
// 32-bit multiple-input signature register with synchronous clear and enable.
module cell_exerciser_misr
    import cell_exerciser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
        end
    end

endmodule

// File: rtl/wb_cell_exerciser.sv
// Wishbone classic responder that drives a cell-under-test input vector and
// captures its outputs; optional done interrupt under CELL_EXERCISER_IRQ_EN.
module wb_cell_exerciser #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NIN        = 16,
    parameter int          NOUT       = 4,
    parameter int          SETTLE_CYC = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [NIN-1:0]  cut_in,
    input  logic [NOUT-1:0] cut_out
`ifdef CELL_EXERCISER_IRQ_EN
    ,
    output logic            irq
`endif
);
    import cell_exerciser_pkg::*;

    state_t          state;
    logic            start_q, mode_q, done_q, run_mode;
    logic [NIN-1:0]  drive_q, run_drive;
    logic [31:0]     count_q, run_count, pidx;
    logic [NOUT-1:0] sample_q;
    logic [7:0]      settle_cnt;
    logic [31:0]     sig, rd_data;
    logic [7:0]      off;
    logic            hit, wr, busy, ctrl_wr, clr_req, done_entry;

    assign off     = wbs_adr_i[7:0];
    assign hit     = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr      = hit && wbs_we_i;
    assign busy    = (state != ST_IDLE) || start_q;
    assign ctrl_wr = wr && (off == OFF_CTRL) && wbs_sel_i[0] && !busy;
    assign clr_req = ctrl_wr && wbs_dat_i[CTRL_CLR];

    // A sweep with COUNT==0 skips straight to DONE; otherwise DONE follows the last capture.
    assign done_entry = (state == ST_IDLE && start_q && mode_q && count_q == 32'h0) ||
                        (state == ST_CAPTURE && (!run_mode || pidx == run_count - 32'd1));

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_STATUS: begin
                rd_data[STAT_BUSY]          = busy;
                rd_data[STAT_DONE]          = done_q;
                rd_data[STAT_STATE_LSB +: 8] = 8'(state);
            end
            OFF_DRIVE:  rd_data = 32'(drive_q);
            OFF_SAMPLE: rd_data = 32'(sample_q);
            OFF_COUNT:  rd_data = count_q;
            OFF_SIG:    rd_data = sig;
            OFF_PIDX:   rd_data = pidx;
            default:    rd_data = '0;
        endcase
    end

    cell_exerciser_misr u_misr (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (clr_req),
        .en  (state == ST_CAPTURE),
        .din (32'(cut_out)),
        .sig (sig)
    );

    // Register writes land on the sampling edge so they are visible during ack;
    // START is held one cycle in start_q, which the FSM consumes from IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            cut_in     <= '0;
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
            run_mode   <= 1'b0;
            drive_q    <= '0;
            run_drive  <= '0;
            count_q    <= '0;
            run_count  <= '0;
            pidx       <= '0;
            sample_q   <= '0;
            settle_cnt <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit && !wbs_we_i) ? rd_data : 32'h0;
            start_q   <= 1'b0;

            if (ctrl_wr) begin
                mode_q  <= wbs_dat_i[CTRL_MODE];
                start_q <= wbs_dat_i[CTRL_START];
                if (wbs_dat_i[CTRL_CLR]) begin
                    sample_q <= '0;
                    done_q   <= 1'b0;
                end
            end
            if (wr && off == OFF_DRIVE)
                drive_q <= NIN'(apply_sel(32'(drive_q), wbs_dat_i, wbs_sel_i));
            if (wr && off == OFF_COUNT)
                count_q <= apply_sel(count_q, wbs_dat_i, wbs_sel_i);

            case (state)
                ST_IDLE: begin
                    if (start_q) begin
                        run_mode  <= mode_q;
                        run_drive <= drive_q;
                        run_count <= count_q;
                        pidx      <= '0;
                        done_q    <= done_entry;
                        state     <= done_entry ? ST_DONE : ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    cut_in     <= run_mode ? pidx[NIN-1:0] : run_drive;
                    settle_cnt <= 8'(SETTLE_CYC - 1);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) state <= ST_CAPTURE;
                    else                    settle_cnt <= settle_cnt - 8'd1;
                end
                ST_CAPTURE: begin
                    sample_q <= cut_out;
                    if (done_entry) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        pidx  <= pidx + 32'd1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef CELL_EXERCISER_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq <= 1'b0;
        else          irq <= done_entry;
    end
`endif

endmodule
